// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter family.
//   BCD_W      : width of one BCD digit
//   BCD_MAX    : largest legal digit value
//   bcd_mode_e : step direction for a digit cell
//   bcd_clamp  : saturates a raw nibble into the legal 0..9 range
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic {
        MODE_DEC = 1'b0,
        MODE_INC = 1'b1
    } bcd_mode_e;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One combinational BCD digit slice of a ripple up/down counter.
// Ports:
//   digit      : current digit value (0..9)
//   carry_in   : increment request from the lower digits (inc mode)
//   borrow_in  : decrement request from the lower digits (dec mode)
//   mode       : MODE_INC or MODE_DEC
//   digit_next : digit value after the step
//   carry_out  : digit is 9 and is being incremented
//   borrow_out : digit is 0 and is being decremented
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             carry_in,
    input  logic             borrow_in,
    input  bcd_mode_e        mode,
    output logic [BCD_W-1:0] digit_next,
    output logic             carry_out,
    output logic             borrow_out
);

    always_comb begin
        digit_next = digit;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        if (mode == MODE_INC) begin
            carry_out = carry_in && (digit == BCD_MAX);
            if (carry_in) begin
                digit_next = (digit == BCD_MAX) ? '0 : digit + 1'b1;
            end
        end else begin
            borrow_out = borrow_in && (digit == '0);
            if (borrow_in) begin
                digit_next = (digit == '0) ? BCD_MAX : digit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_multi_counter.sv
// Parametrised N-digit BCD up/down counter with clear, clamped parallel load,
// wrap or saturate at the limits, and limit / rollover status.
// Parameters:
//   DIGITS : number of BCD digits (1..8), digit 0 least significant
//   WRAP   : 1 = wrap around at the limits with a rollover pulse, 0 = saturate
// Ports:
//   clk      : clock, all state on rising edge
//   reset    : asynchronous active-high reset
//   clr      : synchronous clear (highest priority)
//   load     : synchronous load of load_val, nibbles clamped to 9
//   load_val : packed BCD load value
//   inc/dec  : count up / down; both high is a no-op
//   digits   : registered packed BCD value
//   at_zero  : all digits 0
//   at_max   : all digits 9
//   rollover : one-cycle registered pulse after a wrap
module bcd_multi_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    input  logic                    inc,
    input  logic                    dec,
    output logic [BCD_W*DIGITS-1:0] digits,
    output logic                    at_zero,
    output logic                    at_max,
    output logic                    rollover
);

    localparam int W = BCD_W * DIGITS;

    logic [W-1:0]      digits_reg;
    logic [W-1:0]      digits_next;
    logic [W-1:0]      step_val;
    logic [W-1:0]      clamp_val;
    logic [DIGITS:0]   carry;
    logic [DIGITS:0]   borrow;
    logic [DIGITS-1:0] digit_is_max;
    logic              rollover_reg;
    logic              rollover_next;
    logic              cmd_inc;
    logic              cmd_dec;
    logic              limit_hit;
    bcd_mode_e         mode;

    // inc and dec together cancel out.
    assign cmd_inc = inc & ~dec;
    assign cmd_dec = dec & ~inc;
    assign mode    = cmd_inc ? MODE_INC : MODE_DEC;

    // The chain is seeded by the command itself, so with no command the
    // ripple result equals the current value.
    assign carry[0]  = cmd_inc;
    assign borrow[0] = cmd_dec;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_cell u_cell (
                .digit      (digits_reg[BCD_W*gi +: BCD_W]),
                .carry_in   (carry[gi]),
                .borrow_in  (borrow[gi]),
                .mode       (mode),
                .digit_next (step_val[BCD_W*gi +: BCD_W]),
                .carry_out  (carry[gi+1]),
                .borrow_out (borrow[gi+1])
            );

            assign clamp_val[BCD_W*gi +: BCD_W] = bcd_clamp(load_val[BCD_W*gi +: BCD_W]);
            assign digit_is_max[gi] = (digits_reg[BCD_W*gi +: BCD_W] == BCD_MAX);
        end
    endgenerate

    // A carry or borrow leaving the top digit means the step crossed a limit;
    // the ripple result is then already the wrapped value.
    assign limit_hit = carry[DIGITS] | borrow[DIGITS];

    always_comb begin
        digits_next   = digits_reg;
        rollover_next = 1'b0;
        if (clr) begin
            digits_next = '0;
        end else if (load) begin
            digits_next = clamp_val;
        end else if (cmd_inc || cmd_dec) begin
            if (!(limit_hit && !WRAP)) begin
                digits_next   = step_val;
                rollover_next = limit_hit;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_reg   <= '0;
            rollover_reg <= 1'b0;
        end else begin
            digits_reg   <= digits_next;
            rollover_reg <= rollover_next;
        end
    end

    assign digits   = digits_reg;
    assign rollover = rollover_reg;
    assign at_zero  = (digits_reg == '0);
    assign at_max   = &digit_is_max;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Scoreboard bench: two counters (4 digits wrapping, 2 digits saturating)
// share one command stream. An integer reference model predicts each cycle's
// result, which is queued and compared by an independent monitor process.
module tb_bcd_multi_counter;

    localparam int DA = 4;
    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr, load, inc, dec;
    logic [15:0] lv_a;
    logic [7:0]  lv_b;
    logic [15:0] dig_a;
    logic [7:0]  dig_b;
    logic        z_a, m_a, r_a, z_b, m_b, r_b;

    assign lv_b = lv_a[7:0];

    always #5 clk = ~clk;

    bcd_multi_counter #(.DIGITS(DA), .WRAP(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv_a),
        .inc(inc), .dec(dec), .digits(dig_a), .at_zero(z_a), .at_max(m_a),
        .rollover(r_a)
    );

    bcd_multi_counter #(.DIGITS(DB), .WRAP(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv_b),
        .inc(inc), .dec(dec), .digits(dig_b), .at_zero(z_b), .at_max(m_b),
        .rollover(r_b)
    );

    typedef struct {
        logic [15:0] d;
        bit          z;
        bit          m;
        bit          ro;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   val_a   = 0;
    int   val_b   = 0;
    bit   verbose = 1'b1;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r *= 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v, input int n);
        logic [15:0] b = '0;
        for (int k = 0; k < n; k++) b[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return b;
    endfunction

    // Counter behaviour as plain integer arithmetic on the decimal value.
    function automatic int model_next(input int cur, input int n, input bit wrap,
                                      input bit c, input bit l, input logic [15:0] lv,
                                      input bit i, input bit d, output bit ro);
        int mx = pow10(n) - 1;
        int nv = cur;
        ro = 1'b0;
        if (c) begin
            nv = 0;
        end else if (l) begin
            nv = 0;
            for (int k = 0; k < n; k++) begin
                int nib = int'(lv[4*k +: 4]);
                if (nib > 9) nib = 9;
                nv += nib * pow10(k);
            end
        end else if (i && !d) begin
            if (cur == mx) begin
                if (wrap) begin nv = 0; ro = 1'b1; end
            end else nv = cur + 1;
        end else if (d && !i) begin
            if (cur == 0) begin
                if (wrap) begin nv = mx; ro = 1'b1; end
            end else nv = cur - 1;
        end
        return nv;
    endfunction

    function automatic exp_t mk(input int v, input int n, input bit ro);
        exp_t e;
        e.d  = to_bcd(v, n);
        e.z  = (v == 0);
        e.m  = (v == pow10(n) - 1);
        e.ro = ro;
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Issue one command for one cycle and queue the predicted result.
    task automatic step(input bit c, input bit l, input logic [15:0] lv,
                        input bit i, input bit d);
        bit ro_a, ro_b;
        @(negedge clk);
        clr = c; load = l; lv_a = lv; inc = i; dec = d;
        val_a = model_next(val_a, DA, 1'b1, c, l, lv, i, d, ro_a);
        val_b = model_next(val_b, DB, 1'b0, c, l, lv, i, d, ro_b);
        qa.push_back(mk(val_a, DA, ro_a));
        qb.push_back(mk(val_b, DB, ro_b));
        if (verbose)
            $display("cmd clr=%0b load=%0b lv=%h inc=%0b dec=%0b -> exp a=%04d b=%02d", c, l, lv, i, d, val_a, val_b);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a_digits"}, dig_a, 16'h0000);
        chk({tag, "_a_at_zero"}, 16'(z_a), 16'd1);
        chk({tag, "_a_at_max"}, 16'(m_a), 16'd0);
        chk({tag, "_a_rollover"}, 16'(r_a), 16'd0);
        chk({tag, "_b_digits"}, 16'(dig_b), 16'h0000);
        chk({tag, "_b_at_zero"}, 16'(z_b), 16'd1);
        chk({tag, "_b_rollover"}, 16'(r_b), 16'd0);
    endtask

    // Monitor: each DUT presents a new result every cycle; compare against
    // whatever the stimulus side queued for that cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_digits", dig_a, e.d);
                chk("a_at_zero", 16'(z_a), 16'(e.z));
                chk("a_at_max", 16'(m_a), 16'(e.m));
                chk("a_rollover", 16'(r_a), 16'(e.ro));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_digits", 16'(dig_b), e.d);
                chk("b_at_zero", 16'(z_b), 16'(e.z));
                chk("b_at_max", 16'(m_b), 16'(e.m));
                chk("b_rollover", 16'(r_b), 16'(e.ro));
            end
        end
    end

    initial begin
        reset = 1'b1; clr = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0; lv_a = '0;
        #1;
        chk_reset_state("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted between edges mid-count.
        step(1'b0, 1'b1, 16'h0047, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        clr = 1'b0; load = 1'b0; inc = 1'b1; dec = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_state("async_rst");
        @(negedge clk);
        chk_reset_state("rst_hold");
        reset = 1'b0; inc = 1'b0;
        val_a = 0; val_b = 0;

        // Carry ripple and borrow back.
        step(1'b0, 1'b1, 16'h0099, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Upper limit: A wraps with a pulse, B saturates.
        step(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        // Lower limit.
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Priority, clamping and simultaneous inc/dec.
        step(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h003C, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'hF3AC, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0039, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Random commands, loads biased toward values near the limits.
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [15:0] lv;
            r  = int'($urandom_range(0, 99));
            lv = 16'($urandom);
            if (r >= 10 && r < 15) lv = 16'h9998;
            if (r >= 15 && r < 20) lv = 16'h0001;
            step(r < 4, r >= 4 && r < 20, lv, 1'($urandom), 1'($urandom));
        end

        // Full throughput: 10000 consecutive increments wrap A exactly once.
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        verbose = 1'b0;
        repeat (10000) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        verbose = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        @(negedge clk);
        inc = 1'b0;
        @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
